reg_bank_rw: RTL and testbench

Register bank that consumes the destination index produced by the RegDst write-address selection and serves the two source-operand reads of the multi-cycle MIPS datapath. It has 32 × 32-bit registers, one write port and two registered read ports (rs, rt). Register $0 is hardwired to zero and $29 (sp) resets to 227. A sequenced clear engine re-initialises the bank one register per cycle on request.

---
 rtl/reg_bank_rw.sv | 106 ++++++++++
 tb/tb_reg_bank_rw.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rw.sv
// 32 x DATA_W register bank with registered rs/rt read ports and a one-register-per-cycle clear sweep.
// Define REGBANK_BYPASS_EN to make a same-edge write visible to a read of that address (write-through).
module reg_bank_rw #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              clear,
  output logic              busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [4:0] SP_IDX   = 5'd29;
  localparam logic [4:0] LAST_IDX = 5'd31;

  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_RESET);

  logic [0:0]        state;
  logic [4:0]        idx;
  logic [DATA_W-1:0] regs [32];

  logic              wr_accept;
  logic [DATA_W-1:0] clr_val;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  assign busy      = (state == ST_CLEAR);
  assign wr_accept = wr_en && (state == ST_IDLE) && (wr_addr != 5'd0);
  assign clr_val   = (idx == SP_IDX) ? SP_VAL : '0;

  // Clear sequencer: one register per cycle, a second clear request mid-sweep is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
            idx   <= 5'd0;
          end
        end
        ST_CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
          end
          idx <= idx + 5'd1;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= 5'd0;
        end
      endcase
    end
  end

  // Storage: the clear sweep owns the write port while busy, so external writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_VAL : '0;
      end
    end else if (state == ST_CLEAR) begin
      regs[idx] <= clr_val;
    end else if (wr_accept) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read selection; register 0 reads as zero regardless of storage contents.
  always_comb begin
    rs_next = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    rt_next = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
`ifdef REGBANK_BYPASS_EN
    if (wr_accept && (wr_addr == rs_addr)) begin
      rs_next = wr_data;
    end
    if (wr_accept && (wr_addr == rt_addr)) begin
      rt_next = wr_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_data <= '0;
      rt_data <= '0;
    end else if (rd_en) begin
      rs_data <= rs_next;
      rt_data <= rt_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_rw.sv
// Randomised scoreboard bench for reg_bank_rw: stimulus pushes expected outputs, a monitor pops and compares.
// Honours REGBANK_BYPASS_EN in its reference model.
module tb_reg_bank_rw;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        clear;
  logic        busy;

  reg_bank_rw #(.SP_RESET(32'd227), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        bsy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          done     = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_busy;
  int          m_pos;
  logic [31:0] exp_rs;
  logic [31:0] exp_rt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
    m_busy = 1'b0;
    m_pos  = 0;
    exp_rs = '0;
    exp_rt = '0;
  endtask

  // One clock of stimulus; the reference model predicts the outputs after the next rising edge.
  task automatic applyStimulus(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic ren, input logic [4:0] rsa, input logic [4:0] rta,
                               input logic clr);
    bit          wacc;
    logic [31:0] rsv;
    logic [31:0] rtv;
    @(negedge clk);
    wr_en = wen; wr_addr = waddr; wr_data = wdata;
    rd_en = ren; rs_addr = rsa; rt_addr = rta; clear = clr;
    wacc = wen && !m_busy && (waddr != 5'd0);
    rsv = (rsa == 5'd0) ? 32'd0 : m_regs[rsa];
    rtv = (rta == 5'd0) ? 32'd0 : m_regs[rta];
`ifdef REGBANK_BYPASS_EN
    if (wacc && waddr == rsa) rsv = wdata;
    if (wacc && waddr == rta) rtv = wdata;
`endif
    if (ren) begin
      exp_rs = rsv;
      exp_rt = rtv;
    end
    if (m_busy) begin
      m_regs[m_pos] = (m_pos == 29) ? 32'd227 : 32'd0;
      m_pos++;
      if (m_pos == 32) m_busy = 1'b0;
    end else begin
      if (wacc) m_regs[waddr] = wdata;
      if (clr) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
    exp_q.push_back('{rs: exp_rs, rt: exp_rt, bsy: m_busy});
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic doRead(input logic [4:0] a, input logic [4:0] b);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, a, b, 1'b0);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must drop before any clock edge arrives.
  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_rs", rs_data, 32'd0);
    checkOutput("reset_rt", rt_data, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic fillIndex();
    for (int i = 1; i < 32; i++) doWrite(5'(i), 32'(i));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      if (!reset && !done) begin
        #1;
        if (exp_q.size() == 0) begin
          checkOutput("queue_underflow", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("rs_data", rs_data, e.rs);
          checkOutput("rt_data", rt_data, e.rt);
          checkOutput("busy", {31'd0, busy}, {31'd0, e.bsy});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rs_addr = '0; rt_addr = '0; clear = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    pulseReset();

    doRead(5'd29, 5'd0);
    doRead(5'd5, 5'd29);
    doIdle();

    doWrite(5'd31, 32'hDEADBEEF);
    doWrite(5'd0, 32'h12345678);
    doRead(5'd31, 5'd0);

    doWrite(5'd8, 32'h1);
    applyStimulus(1'b1, 5'd8, 32'hA5A5A5A5, 1'b1, 5'd8, 5'd31, 1'b0);
    doRead(5'd8, 5'd8);

    fillIndex();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int c = 1; c < 34; c++) begin
      if (c == 5) applyStimulus(1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 5'd30, 1'b0);
      else applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(c), 5'(31 - c), 1'b0);
    end
    for (int i = 0; i < 32; i += 2) doRead(5'(i), 5'(i + 1));

    fillIndex();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int c = 1; c < 36; c++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, c == 10);

    fillIndex();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int c = 1; c < 15; c++) doRead(5'd20, 5'd1);
    pulseReset();
    doRead(5'd20, 5'd29);
    doRead(5'd3, 5'd31);

    for (int n = 0; n < 600; n++) begin
      logic [4:0]  wa;
      logic [4:0]  ra;
      logic [4:0]  rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, ($urandom_range(0, 3) != 0),
                    ra, rb, ($urandom_range(0, 79) == 0));
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
